// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter command sequencer: FSM states and the latched command.
// Command field widths come from CTRL_WIDTH/CTRL_STEPS_W; instances must use matching parameters.
package counter_ctrl_pkg;

  localparam int CTRL_WIDTH   = 4;
  localparam int CTRL_STEPS_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic                    dir;
    logic [CTRL_WIDTH-1:0]   start;
    logic [CTRL_STEPS_W-1:0] steps;
  } ctrl_cmd_t;

endpackage

// File: rtl/counter_ctrl_step_cnt.sv
// Remaining-steps down-counter: loaded with the step count on command acceptance,
// decremented once per enabled count cycle; is_one flags the final step.
module counter_ctrl_step_cnt #(
  parameter int STEPS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [STEPS_W-1:0] load_val,
  input  logic               dec,
  output logic               is_one
);

  logic [STEPS_W-1:0] cnt_q;
  logic [STEPS_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - STEPS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one = (cnt_q == STEPS_W'(1));

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for the up/down counter: load start value, step N cycles, report result.
// Optional saturation stop is compiled in with COUNTER_CTRL_SAT_EN.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH   = CTRL_WIDTH,
  parameter int STEPS_W = CTRL_STEPS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [WIDTH-1:0]   cmd_start,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               abort,
  output logic               load_n,
  output logic               ce,
  output logic               up_down,
  output logic [WIDTH-1:0]   data_load,
  input  logic [WIDTH-1:0]   count_out,
  input  logic               max_count,
  input  logic               zero,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               sat,
  output logic               aborted
);

  ctrl_state_t      state_q, state_d;
  ctrl_cmd_t        cmd_q;
  logic [WIDTH-1:0] result_q;
  logic             aborted_q;
  logic             accept;
  logic             step_dec;
  logic             step_is_one;
  logic             sat_hit;
  logic             set_sat;
  logic             set_abort;

  assign accept = cmd_valid && (state_q == IDLE);

  counter_ctrl_step_cnt #(
    .STEPS_W (STEPS_W)
  ) u_step_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (cmd_steps),
    .dec      (step_dec),
    .is_one   (step_is_one)
  );

  // Abort wins over saturation, which wins over normal step completion.
  always_comb begin
    state_d   = state_q;
    load_n    = 1'b1;
    ce        = 1'b0;
    step_dec  = 1'b0;
    set_sat   = 1'b0;
    set_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        if (abort) begin
          state_d   = DONE;
          set_abort = 1'b1;
        end else begin
          load_n  = 1'b0;
          state_d = (cmd_q.steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = DONE;
          set_abort = 1'b1;
        end else if (sat_hit) begin
          state_d = DONE;
          set_sat = 1'b1;
        end else begin
          ce       = 1'b1;
          step_dec = 1'b1;
          if (step_is_one) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      result_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q <= '{dir: cmd_dir, start: cmd_start, steps: cmd_steps};
      end
      if (accept) begin
        aborted_q <= 1'b0;
      end else if (set_abort) begin
        aborted_q <= 1'b1;
      end
      if (state_q == DONE) begin
        result_q <= count_out;
      end
    end
  end

`ifdef COUNTER_CTRL_SAT_EN
  logic sat_q;

  assign sat_hit = (state_q == RUN) && (cmd_q.dir ? max_count : zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (accept) begin
      sat_q <= 1'b0;
    end else if (set_sat) begin
      sat_q <= 1'b1;
    end
  end

  assign sat = sat_q;
`else
  logic unused_sat;

  assign sat_hit    = 1'b0;
  assign unused_sat = &{1'b0, max_count, zero, set_sat};
  assign sat        = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign up_down   = cmd_q.dir;
  assign data_load = cmd_q.start;
  // During DONE the live count is the result; the register keeps it afterwards.
  assign result    = (state_q == DONE) ? count_out : result_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl with a behavioural counter attached; table vectors, corner sequences, random commands.
module tb_counter_ctrl;

  localparam int W  = 4;
  localparam int SW = 8;
`ifdef COUNTER_CTRL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [W-1:0]  cmd_start;
  logic [SW-1:0] cmd_steps;
  logic          abort;
  logic          load_n;
  logic          ce;
  logic          up_down;
  logic [W-1:0]  data_load;
  logic [W-1:0]  count_out;
  logic          max_count;
  logic          zero;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          sat;
  logic          aborted;

  counter_ctrl #(.WIDTH(W), .STEPS_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_start (cmd_start),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .load_n    (load_n),
    .ce        (ce),
    .up_down   (up_down),
    .data_load (data_load),
    .count_out (count_out),
    .max_count (max_count),
    .zero      (zero),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .sat       (sat),
    .aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter instance the controller drives
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (!load_n) cnt <= data_load;
    else if (ce)      cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
  end
  assign count_out = cnt;
  assign max_count = &cnt;
  assign zero      = (cnt == '0);

  int errors = 0;
  int checks = 0;
  logic [W-1:0] trace [0:299];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the steps with plain modular arithmetic.
  function automatic void model(input logic dir, input logic [W-1:0] start, input int steps,
                                input int abort_k, input logic [W-1:0] prev,
                                output int done_k, output logic [W-1:0] res,
                                output logic s, output logic a, output int ce_n);
    int v;
    v = int'(start); s = 1'b0; a = 1'b0; ce_n = 0;
    if (abort_k == 1) begin
      done_k = 2; res = prev; a = 1'b1;
      return;
    end
    for (int i = 0; i < steps; i++) begin
      int k;
      k = 2 + i;
      if (abort_k == k) begin
        a = 1'b1; done_k = k + 1; res = v[W-1:0];
        return;
      end
      if (SAT_EN && ((dir && v == 15) || (!dir && v == 0))) begin
        s = 1'b1; done_k = k + 1; res = v[W-1:0];
        return;
      end
      v = dir ? (v + 1) % 16 : (v + 15) % 16;
      ce_n++;
    end
    done_k = 2 + steps;
    res = v[W-1:0];
  endfunction

  // k counts cycles after the acceptance edge: k=1 is LOAD.
  task automatic do_cmd(input logic dir, input logic [W-1:0] start, input logic [SW-1:0] steps,
                        input int abort_k, input bit hold,
                        output int done_k, output logic [W-1:0] res, output logic s, output logic a,
                        output int ce_n, output int load_k, output int ce_at_abort, output int rdy_n);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!cmd_ready && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_start = start; cmd_steps = steps;
    done_k = -1; res = '0; s = 1'b0; a = 1'b0;
    ce_n = 0; load_k = -1; ce_at_abort = -1; rdy_n = 0;
    for (int k = 1; k < 300; k++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      else if (k == 1) begin
        cmd_dir = 1'b1; cmd_start = 4'hA; cmd_steps = 8'd2;
      end
      abort = (k == abort_k);
      #1;
      trace[k] = count_out;
      if (cmd_ready) rdy_n++;
      if (!load_n && load_k < 0) load_k = k;
      if (ce) ce_n++;
      if (k == abort_k) ce_at_abort = int'(ce);
      if (done) begin
        done_k = k; res = result; s = sat; a = aborted;
        break;
      end
    end
    abort = 1'b0;
    if (done_k < 0) chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic         dir;
    logic [W-1:0] start;
    int           steps;
    int           abort_k;
    int           done_k;
    logic [W-1:0] res;
    logic         s;
    logic         a;
    int           ce_n;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int done_k, ce_n, load_k, ce_ab, rdy_n, edone, ece, dpulses;
    logic [W-1:0] res, eres, prev;
    logic s, a, es, ea;

    tbl[0] = '{1'b1, 4'd3, 4, 0, 6, 4'd7, 1'b0, 1'b0, 4};
    tbl[1] = '{1'b0, 4'd9, 0, 0, 2, 4'd9, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b1, 4'd5, 3, 1, 2, 4'd9, 1'b0, 1'b1, 0};
`ifdef COUNTER_CTRL_SAT_EN
    tbl[3] = '{1'b0, 4'd1, 3, 0, 4, 4'd0, 1'b1, 1'b0, 1};
`else
    tbl[3] = '{1'b0, 4'd1, 3, 0, 5, 4'd14, 1'b0, 1'b0, 3};
`endif
    tbl[4] = '{1'b1, 4'd0, 10, 4, 5, 4'd2, 1'b0, 1'b1, 2};
`ifdef COUNTER_CTRL_SAT_EN
    tbl[5] = '{1'b1, 4'd14, 3, 0, 4, 4'd15, 1'b1, 1'b0, 1};
    tbl[6] = '{1'b1, 4'd15, 1, 0, 3, 4'd15, 1'b1, 1'b0, 0};
`else
    tbl[5] = '{1'b1, 4'd14, 3, 0, 5, 4'd1, 1'b0, 1'b0, 3};
    tbl[6] = '{1'b1, 4'd15, 1, 0, 3, 4'd0, 1'b0, 1'b0, 1};
`endif

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_start = '0; cmd_steps = '0; abort = 1'b0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load_n", load_n, 1);
    chk("rst_ce", ce, 0);
    chk("rst_up_down", up_down, 0);
    chk("rst_data_load", data_load, 0);
    chk("rst_result", result, 0);
    chk("rst_sat", sat, 0);
    chk("rst_aborted", aborted, 0);
    #5 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_cmd(tbl[i].dir, tbl[i].start, SW'(tbl[i].steps), tbl[i].abort_k, 1'b0,
             done_k, res, s, a, ce_n, load_k, ce_ab, rdy_n);
      chk($sformatf("tbl%0d_done_cycle", i), done_k, tbl[i].done_k);
      chk($sformatf("tbl%0d_result", i), res, tbl[i].res);
      chk($sformatf("tbl%0d_sat", i), s, tbl[i].s);
      chk($sformatf("tbl%0d_aborted", i), a, tbl[i].a);
      chk($sformatf("tbl%0d_ce_cycles", i), ce_n, tbl[i].ce_n);
      chk($sformatf("tbl%0d_ready_while_busy", i), rdy_n, 0);
      chk($sformatf("tbl%0d_load_cycle", i), load_k, (tbl[i].abort_k == 1) ? -1 : 1);
      if (tbl[i].abort_k > 1) chk($sformatf("tbl%0d_ce_in_abort", i), ce_ab, 0);
      if (i == 0) begin
        for (int k = 2; k <= 6; k++) chk($sformatf("seq_count_k%0d", k), trace[k], k + 1);
      end
    end

    // cmd_valid held through the whole command; re-accepted only after DONE
    do_cmd(1'b1, 4'd1, 8'd5, 0, 1'b1, done_k, res, s, a, ce_n, load_k, ce_ab, rdy_n);
    chk("hold_done_cycle", done_k, 7);
    chk("hold_result", res, 6);
    chk("hold_ready_while_busy", rdy_n, 0);
    @(negedge clk); #1;
    chk("hold_ready_after_done", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("hold_second_load_n", load_n, 0);
    chk("hold_second_data_load", data_load, 4'hA);
    done_k = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (done) begin
        done_k = k;
        break;
      end
    end
    chk("hold_second_done_seen", (done_k >= 0), 1);
    chk("hold_second_result", result, 4'hC);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_start = 4'd7; cmd_steps = 8'd20;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_ce", ce, 0);
    chk("midrst_load_n", load_n, 1);
    chk("midrst_up_down", up_down, 0);
    chk("midrst_data_load", data_load, 0);
    chk("midrst_result", result, 0);
    chk("midrst_done", done, 0);
    chk("midrst_aborted", aborted, 0);
    #10 rst_n = 1'b1;
    dpulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (done) dpulses++;
    end
    chk("midrst_no_done", dpulses, 0);
    do_cmd(1'b0, 4'd3, 8'd2, 0, 1'b0, done_k, res, s, a, ce_n, load_k, ce_ab, rdy_n);
    chk("midrst_restart_done", done_k, 4);
    chk("midrst_restart_result", res, 1);
    prev = res;

    // Random commands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic         rdir;
      logic [W-1:0] rstart;
      int           rsteps, rab;
      rdir   = 1'($urandom_range(0, 1));
      rstart = W'($urandom_range(0, 15));
      rsteps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 24));
      rab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rsteps + 3)) : 0;
      model(rdir, rstart, rsteps, rab, prev, edone, eres, es, ea, ece);
      do_cmd(rdir, rstart, SW'(rsteps), rab, 1'b0, done_k, res, s, a, ce_n, load_k, ce_ab, rdy_n);
      chk($sformatf("rnd%0d_done_cycle", i), done_k, edone);
      chk($sformatf("rnd%0d_result", i), res, eres);
      chk($sformatf("rnd%0d_sat", i), s, es);
      chk($sformatf("rnd%0d_aborted", i), a, ea);
      chk($sformatf("rnd%0d_ce_cycles", i), ce_n, ece);
      prev = eres;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Command-driven sequencer for the shared up/down counter (`load_n`, `ce`, `up_down`, `data_load` / `count_out`, `max_count`, `zero`). It accepts one command at a time over a valid/ready handshake. For each command it loads a start value, then steps the counter a programmed number of cycles in one direction. It then reports completion with the final count. It sits between a register/config agent and the counter instance and is the only driver of the counter's control inputs.

## Interface
- `WIDTH`, default 4: counter width; must match the counter instance.
- `STEPS_W`, default 8: width of the step-count field.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset. It is shared with the counter instance.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: controller can accept; high only in IDLE.
- `cmd_dir` input 1: 1 = count up, 0 = count down.
- `cmd_start` input WIDTH: value loaded into the counter.
- `cmd_steps` input STEPS_W: number of enabled count cycles; 0 is legal.
- `abort` input 1: terminate the current command early.
- `load_n` output 1: counter load, active low.
- `ce` output 1: counter enable.
- `up_down` output 1: counter direction.
- `data_load` output WIDTH: counter load value.
- `count_out` input WIDTH: counter value.
- `max_count` input 1: counter at all-ones.
- `zero` input 1: counter at all-zeros.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle completion pulse.
- `result` output WIDTH: final count.
- `sat` output 1: command ended on saturation.
- `aborted` output 1: command ended on abort.

## Operation
- States and transitions:
  - IDLE: accepting commands. Goes to LOAD on `cmd_valid && cmd_ready`.
  - LOAD: one cycle. Goes to RUN when steps is non-zero, otherwise to DONE.
  - RUN: one enabled count cycle per step. Goes to DONE when the remaining-steps counter reaches 0, on abort, or on saturation.
  - DONE: one cycle. Returns to IDLE.
- Command latching:
  - On acceptance, `cmd_dir`, `cmd_start` and `cmd_steps` are latched.
  - `sat` and `aborted` are cleared on acceptance.
- LOAD: drives `load_n`=0 and `data_load`=latched start; `ce`=0.
- RUN:
  - Drives `load_n`=1, `ce`=1 and `up_down`=latched dir.
  - The remaining-steps counter decrements on each cycle with `ce`=1.
  - RUN exits after the cycle where remaining steps goes 1→0.
- Abort:
  - Sampled in LOAD or RUN only; ignored in IDLE and DONE.
  - In the cycle `abort`=1, `ce`=0 and `load_n`=1, combinationally gated.
  - Next state is DONE and `aborted` is set.
  - Abort has priority over saturation and step completion.
- DONE:
  - `done`=1 and `result`=`count_out`.
  - `result` register captures `count_out` at the DONE edge and holds it until the next DONE.
- Outside LOAD: `data_load` holds its last value, and `up_down` holds the latched dir.
- Step arithmetic: the step count is unsigned. The counter itself wraps modulo 2^WIDTH unless saturation is compiled in.

## Timing
- Command accepted at the edge ending cycle T:
  - LOAD in T+1.
  - Counter holds start from T+2.
  - RUN occupies T+2 … T+1+steps.
  - DONE in T+2+steps.
  - The next command can be accepted in T+3+steps.
- `steps`=0: DONE in T+2 and `ce` is never asserted.
- Controller-to-counter outputs are combinational decodes of registered state. `ce` additionally depends on `abort`, `max_count` and `zero`.
- Reset values:
  - State IDLE.
  - `cmd_ready`=1, `busy`=0, `done`=0.
  - `load_n`=1, `ce`=0, `up_down`=0, `data_load`=0.
  - `result`=0, `sat`=0, `aborted`=0.
- Reset asserted mid-command forces reset values immediately, without a clock. The command is lost and `done` is not pulsed.

## Configuration
- `COUNTER_CTRL_SAT_EN` defined:
  - In RUN, if dir=up and `max_count`=1, or dir=down and `zero`=1, the controller drives `ce`=0 that cycle, goes to DONE and sets `sat`.
  - Remaining steps are discarded.
- `COUNTER_CTRL_SAT_EN` undefined:
  - The counter wraps freely.
  - `sat` is tied 0 and `max_count`/`zero` are unused.

## Structure
- `counter_ctrl_pkg`:
  - `ctrl_state_t` enum: IDLE, LOAD, RUN, DONE.
  - `ctrl_cmd_t` packed struct: dir, start, steps, parameterized through package localparams or used with matching widths.
- One sub-module, `counter_ctrl_step_cnt`: a loadable STEPS_W down-counter with `load`, `dec` and `is_one` outputs.

## Test plan
- WIDTH=4, start=3, up, steps=4:
  - `load_n`=0 in T+1.
  - `count_out` sequence 3,4,5,6,7.
  - `done` in T+6 with `result`=7, `sat`=0.
- start=9, steps=0: `done` in T+2, `result`=9, `ce` never high.
- start=1, down, steps=3:
  - Without SAT: result 14 (1→0→15→14).
  - With `COUNTER_CTRL_SAT_EN`: `ce` is low in T+3, `done` in T+4, `result`=0, `sat`=1.
- start=0, up, steps=10, `abort` in third RUN cycle: `ce` is low in that cycle, then `done` next cycle with `result`=2 and `aborted`=1.
- `cmd_valid` held high during RUN:
  - `cmd_ready`=0 and the command is not accepted.
  - It is accepted in the first IDLE cycle after DONE.
- `rst_n` dropped mid-RUN between clock edges: all outputs take reset values immediately and the controller restarts in IDLE.
